// File: rtl/spram_pkg.sv
// Shared types and helpers for the byte-lane single-port RAM with clear engine.
package spram_pkg;

  typedef enum logic {
    CLR_IDLE = 1'b0,
    CLR_BUSY = 1'b1
  } clr_state_t;

  // Upper bound on the data width that lane_mask can expand; the caller
  // slices the low DATA_W bits off the result.
  localparam int MASK_MAX_W = 256;

  // Expand per-lane enables into a per-bit write mask: bit b follows be[b/lane_w].
  function automatic logic [MASK_MAX_W-1:0] lane_mask(input logic [MASK_MAX_W-1:0] be,
                                                      input int lane_w);
    logic [MASK_MAX_W-1:0] m;
    m = '0;
    for (int b = 0; b < MASK_MAX_W; b++) begin
      if (lane_w > 0) m[b] = be[b / lane_w];
    end
    return m;
  endfunction

endpackage

// File: rtl/spram_clear_fsm.sv
// Clear engine: walks every word address once, one per cycle, and flags busy.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  CLR_IDLE | array belongs to the user port; waits for clear_req
//  CLR_BUSY | writing FILL_VAL to mem[cnt]; leaves after the last address
module spram_clear_fsm
  import spram_pkg::*;
#(
  parameter int ADDR_W         = 8,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear_req,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_t        state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;

  // State and address counter; reset lands straight in CLR_BUSY when the
  // array must come up in a known state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? CLR_BUSY : CLR_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state; cnt wraps to 0 exactly as the last word is written.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      CLR_IDLE: begin
        if (clear_req) state_nxt = CLR_BUSY;
      end
      CLR_BUSY: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == LAST_ADDR) state_nxt = CLR_IDLE;
      end
      default: state_nxt = CLR_IDLE;
    endcase
  end

  // busy decodes the state register only, so clear_req never reaches it combinationally.
  assign busy     = (state == CLR_BUSY);
  assign clr_we   = busy;
  assign clr_addr = cnt;

endmodule

// File: rtl/spram_be_clr.sv
// Single-port RAM with byte-lane write enables, optional registered read and
// a clear engine that owns the array while it fills it with FILL_VAL.
module spram_be_clr
  import spram_pkg::*;
#(
  parameter int          ADDR_W         = 8,
  parameter int          DATA_W         = 8,
  parameter int          LANE_W         = 8,
  parameter int unsigned RD_REG         = 0,
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_W-1:0] FILL_VAL = '0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cs,
  input  logic                       wren,
  input  logic [DATA_W/LANE_W-1:0]   be,
  input  logic [ADDR_W-1:0]          address,
  input  logic [DATA_W-1:0]          data,
  output logic [DATA_W-1:0]          q,
  input  logic                       clear_req,
  output logic                       busy
);

  localparam int NLANE = DATA_W / LANE_W;
  localparam int DEPTH = 2 ** ADDR_W;

  if (DATA_W % LANE_W != 0) begin : g_bad_lane
    $error("spram_be_clr: DATA_W must be a multiple of LANE_W");
  end
  if (RD_REG > 1) begin : g_bad_rdreg
    $error("spram_be_clr: RD_REG must be 0 or 1");
  end
  if (DATA_W >= MASK_MAX_W) begin : g_bad_width
    $error("spram_be_clr: DATA_W exceeds lane_mask range");
  end

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  spram_clear_fsm #(
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_fsm (
    .clock    (clock),
    .reset    (reset),
    .clear_req(clear_req),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .busy     (busy)
  );

  logic [MASK_MAX_W-1:0] mask_full;
  logic [DATA_W-1:0]     wmask;
  logic                  unused_mask_hi;

  assign mask_full      = lane_mask(MASK_MAX_W'(be), LANE_W);
  assign wmask          = mask_full[DATA_W-1:0];
  assign unused_mask_hi = ^mask_full[MASK_MAX_W-1:DATA_W];

  logic [DATA_W-1:0] mem [DEPTH];
  logic              user_we;
  logic              rd_en;
  logic [DATA_W-1:0] rd_word;

  assign user_we = cs & wren & ~busy;
  assign rd_en   = cs & ~busy;
  assign rd_word = mem[address];

  // Single write port: the clear engine wins; user writes merge per lane.
  always_ff @(posedge clock) begin
    if (clr_we) begin
      mem[clr_addr] <= FILL_VAL;
    end else if (user_we) begin
      mem[address] <= (rd_word & ~wmask) | (data & wmask);
    end
  end

  if (RD_REG == 1) begin : g_rd_reg
    logic [DATA_W-1:0] q_r;

    // Registered read samples the pre-write word, giving old-data on read-during-write.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) q_r <= '1;
      else       q_r <= rd_en ? rd_word : '1;
    end

    assign q = q_r;
  end else begin : g_rd_async
    assign q = rd_en ? rd_word : '1;
  end

endmodule
